// File: rtl/eq4_input_cond.sv
// eq4_input_cond: synchronise and debounce board switches/buttons into one-cycle comparator commands (optional EQ4_INPUT_SYNC_EN adds 2-flop synchronisers)
module eq4_input_cond #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] btn_raw,
   input  logic [3:0] sw_raw,
   output logic [3:0] test,
   output logic [1:0] pushbutton,
   output logic       busy
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
   state_t st [2];
   state_t st_n [2];
   logic [CW-1:0] cnt [2];
   logic [CW-1:0] cnt_n [2];
   logic [1:0] btn_s, acc_n, accept, pb_n;
   logic [3:0] sw_s;
   logic pend_0;
`ifdef EQ4_INPUT_SYNC_EN
   logic [1:0] b1, b2;
   logic [3:0] s1, s2;
   // two-flop chains bring the asynchronous board levels into the clk domain
   always_ff @(posedge clk) begin
      if (reset) begin
         b1 <= '0;
         b2 <= '0;
         s1 <= '0;
         s2 <= '0;
      end else begin
         b1 <= btn_raw;
         b2 <= b1;
         s1 <= sw_raw;
         s2 <= s1;
      end
   end
   assign btn_s = b2;
   assign sw_s  = s2;
`else
   assign btn_s = btn_raw;
   assign sw_s  = sw_raw;
`endif
   // per-button debounce FSM: a level must hold DEBOUNCE_CYCLES samples to be accepted
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_n[i]  = st[i];
         cnt_n[i] = cnt[i];
         acc_n[i] = 1'b0;
         case (st[i])
            IDLE: if (btn_s[i]) begin
               st_n[i]  = PRESS_DB;
               cnt_n[i] = CW'(1);
            end
            PRESS_DB: if (!btn_s[i]) begin
               st_n[i]  = IDLE;
               cnt_n[i] = '0;
            end else if (cnt[i] == LAST) begin
               st_n[i]  = HELD;
               cnt_n[i] = '0;
               acc_n[i] = 1'b1;
            end else cnt_n[i] = cnt[i] + 1'b1;
            HELD: if (!btn_s[i]) begin
               st_n[i]  = REL_DB;
               cnt_n[i] = CW'(1);
            end
            REL_DB: if (btn_s[i]) begin
               st_n[i]  = HELD;
               cnt_n[i] = '0;
            end else if (cnt[i] == LAST) begin
               st_n[i]  = IDLE;
               cnt_n[i] = '0;
            end else cnt_n[i] = cnt[i] + 1'b1;
            default: begin
               st_n[i]  = IDLE;
               cnt_n[i] = '0;
            end
         endcase
      end
   end
   // button 1 wins a tie; button 0 is deferred one cycle through pend_0
   always_comb begin
      pb_n = accept[1] ? 2'b10 : (accept[0] | pend_0) ? 2'b01 : 2'b00;
   end
   // state, counters, accept flags and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= '{IDLE, IDLE};
         cnt        <= '{'0, '0};
         accept     <= '0;
         pend_0     <= 1'b0;
         pushbutton <= '0;
         test       <= '0;
      end else begin
         st         <= st_n;
         cnt        <= cnt_n;
         accept     <= acc_n;
         pend_0     <= accept[1] & (accept[0] | pend_0);
         pushbutton <= pb_n;
         test       <= (pb_n != 2'b00) ? sw_s : test;
      end
   end
   assign busy = (st[0] != IDLE) | (st[1] != IDLE);
endmodule

// File: tb/tb_eq4_input_cond.sv
// tb_eq4_input_cond: directed scoreboard bench for eq4_input_cond
module tb_eq4_input_cond;
   localparam int D = 4;
`ifdef EQ4_INPUT_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif
   localparam int LAT = D + SD;
   typedef struct {
      int         cyc;
      logic [1:0] pb;
      logic [3:0] tv;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0] btn_raw = 2'b11;
   logic [3:0] sw_raw = 4'hF;
   logic [3:0] test;
   logic [1:0] pushbutton;
   logic busy;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int n, r;
   exp_t q[$];
   exp_t e;
   logic [6:0] bounce = 7'b1101110;
   eq4_input_cond #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
      .test(test), .pushbutton(pushbutton), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input int c);
      repeat (c) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic expect_pulse(input int at, input logic [1:0] pb, input logic [3:0] tv);
      exp_t x;
      x.cyc = at;
      x.pb = pb;
      x.tv = tv;
      q.push_back(x);
   endtask
   always @(negedge clk) begin
      if (!reset && pushbutton != 2'b00) begin
         if (q.size() == 0) chk("unexpected_pulse", {30'd0, pushbutton}, 32'd0);
         else begin
            e = q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_value", {30'd0, pushbutton}, {30'd0, e.pb});
            chk("pulse_test", {28'd0, test}, {28'd0, e.tv});
         end
      end
   end
   initial begin
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("reset_test", {28'd0, test}, 32'd0);
         chk("reset_pb", {30'd0, pushbutton}, 32'd0);
         chk("reset_busy", {31'd0, busy}, 32'd0);
      end
      btn_raw = 2'b00;
      sw_raw = 4'h0;
      reset = 1'b0;
      step(10);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      sw_raw = 4'hA;
      step(3);
      btn_raw = 2'b10;
      expect_pulse(cyc + 1 + LAT, 2'b10, 4'hA);
      step(3);
      chk("press_busy", {31'd0, busy}, 32'd1);
      step(17);
      btn_raw = 2'b00;
      step(2);
      btn_raw = 2'b10;
      step(6);
      chk("short_release_busy", {31'd0, busy}, 32'd1);
      btn_raw = 2'b00;
      step(8);
      chk("released_busy", {31'd0, busy}, 32'd0);
      btn_raw = 2'b10;
      expect_pulse(cyc + 1 + LAT, 2'b10, 4'hA);
      step(4);
      btn_raw = 2'b00;
      step(12);
      chk("repress_done_busy", {31'd0, busy}, 32'd0);
      sw_raw = 4'h7;
      step(3);
      for (int i = 6; i >= 0; i--) begin
         btn_raw = {1'b0, bounce[i]};
         step(1);
      end
      btn_raw = 2'b01;
      expect_pulse(cyc + 1 + LAT, 2'b01, 4'h7);
      step(12);
      btn_raw = 2'b00;
      step(10);
      sw_raw = 4'h3;
      step(3);
      btn_raw = 2'b11;
      n = cyc;
      expect_pulse(n + 1 + LAT, 2'b10, 4'h3);
      expect_pulse(n + 2 + LAT, 2'b01, 4'h5);
      step(1 + D);
      sw_raw = 4'h5;
      step(10);
      btn_raw = 2'b00;
      step(12);
      chk("simul_done_busy", {31'd0, busy}, 32'd0);
      btn_raw = 2'b01;
      n = cyc;
      step(2 + SD);
      reset = 1'b1;
      step(1);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      r = cyc;
      expect_pulse(r + 1 + LAT, 2'b01, 4'h5);
      step(12);
      chk("held_busy", {31'd0, busy}, 32'd1);
      btn_raw = 2'b00;
      step(12);
      chk("final_busy", {31'd0, busy}, 32'd0);
      chk("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
